vote_session_ctrl: RTL and testbench
====================================

Name: vote_session_ctrl

Overview:
Parametrised, clocked voting controller.
- Opens a voting session and accepts one ballot per voter over a valid/ready handshake.
- Rejects duplicate and out-of-range ballots and keeps running yes/no counts.
- On close, evaluates the result under a selectable rule (simple majority or fixed threshold).
- Sits between voter-interface logic and the result display or decision logic; generalises the 4-input combinational voter to N voters with session state.

Parameters:
N_VOTERS, 4, number of voters; legal range 2..64.
ID_W, $clog2(N_VOTERS) (minimum 1), width of the ballot voter ID.
CNT_W, $clog2(N_VOTERS+1), width of the yes/no counters.
MODE, 0, pass rule: 0 = simple majority of cast votes (yes > no); 1 = threshold (yes >= THRESHOLD).
THRESHOLD, (N_VOTERS/2)+1, yes count required when MODE=1.
TIMEOUT, 256, cycles in OPEN before auto-close (used only with the optional feature).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  open a new session; honoured only in IDLE or DONE.
close  in  1  end the session; honoured only in OPEN.
ballot_valid  in  1  a ballot is presented.
ballot_id  in  ID_W  voter index.
ballot_yes  in  1  1 = yes, 0 = no.
ballot_ready  out  1  high in OPEN only; combinational from state.
ballot_err  out  1  one-cycle pulse, cycle after a rejected ballot.
busy  out  1  high in OPEN and TALLY.
result_valid  out  1  high throughout DONE.
pass  out  1  result; meaningful while result_valid is high.
yes_count  out  CNT_W  running yes total.
no_count  out  CNT_W  running no total.
timed_out  out  1  session ended by timeout (optional feature only).

Behaviour:
Reset:
- Asynchronous; returns the FSM to IDLE.
- Clears the voted mask, counters and timer.
- All outputs 0, including a reset asserted mid-session; the partial tally is discarded.

State IDLE:
- start -> OPEN. On entry, voted mask, counters, ballot_err and pass are cleared.

State OPEN:
- ballot_ready = 1. A handshake (valid & ready) is processed in that cycle.
- Accept when ballot_id < N_VOTERS and voted[ballot_id] = 0:
  - set voted[ballot_id];
  - increment yes_count or no_count, visible the next cycle.
- Reject otherwise: counts unchanged, ballot_err = 1 the next cycle.
- Leave OPEN for TALLY when close = 1, or when the post-update voted mask is all ones (auto-close).
- close and a ballot in the same cycle: the ballot is processed first, then close takes effect.
- start in OPEN is ignored.

State TALLY:
- One cycle. Compute pass per MODE into a register.
- MODE 0: a tie, or zero votes cast, gives pass = 0.
- Counts are frozen.

State DONE:
- result_valid = 1. pass and counts are held.
- start -> OPEN (new session, counters cleared on entry). close is ignored.

Timing:
- Latency from close at cycle t: busy stays high through t+1 (TALLY); result_valid = 1 at t+2.
- Last missing ballot accepted at cycle t: result_valid = 1 at t+2.

Width rules:
- Counters cannot overflow: the voted mask bounds yes_count + no_count at N_VOTERS.
- Threshold compare is unsigned at CNT_W.

Optional Feature:
VOTE_TIMEOUT_EN
Defined:
- A cycle counter clears on OPEN entry and increments each OPEN cycle.
- At TIMEOUT-1 the FSM forces TALLY as if close were asserted; timed_out is set.
- timed_out is held through DONE and cleared on the next OPEN entry.
- An explicit close or auto-close earlier than the timeout leaves timed_out = 0.
Undefined:
- No timer logic is built; the session stays OPEN indefinitely.
- timed_out is tied to 0.

Decomposition:
Package vote_pkg:
- State enum {IDLE, OPEN, TALLY, DONE}.
- MODE_MAJORITY = 0, MODE_THRESHOLD = 1.
- Width helper function for CNT_W.

Sub-module vote_ballot_box:
- Contains the voted mask, duplicate/range check and counters.
- Inputs: clear, accept strobe, id, yes.
- Outputs: yes_count, no_count, all_voted, reject.
- The top level holds the FSM, pass evaluation and timer.

Test Plan:
1. N=4, MODE 0: start; ballots id0..3 = yes, yes, no, yes -> auto-close; result_valid 2 cycles after last ballot; yes_count=3, no_count=1, pass=1.
2. Duplicate and range: id1 yes, then id1 no, then id=5 (N=4) -> ballot_err pulses twice; counts yes=1, no=0.
3. Tie and early close: id0 yes, id1 no, close -> pass=0 (MODE 0). Same votes with MODE=1, THRESHOLD=1 -> pass=1.
4. Simultaneous close + ballot: id2 yes with close in the same cycle -> yes_count includes it; TALLY next cycle.
5. Reset mid-session: 2 ballots accepted, assert rst asynchronously -> all outputs 0 immediately. A new start opens with zero counts and accepts id0 again.
6. With VOTE_TIMEOUT_EN, TIMEOUT=16: start, one ballot, idle -> DONE reached with timed_out=1, result_valid=1. Restart -> timed_out=0.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared FSM state type, pass-rule codes and width helpers for vote_session_ctrl
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        TALLY = 2'd2,
        DONE  = 2'd3
    } vote_state_e;

    localparam int MODE_MAJORITY  = 0;
    localparam int MODE_THRESHOLD = 1;

    function automatic int cnt_width(input int n_voters);
        return $clog2(n_voters + 1);
    endfunction

    function automatic int id_width(input int n_voters);
        return (n_voters > 2) ? $clog2(n_voters) : 1;
    endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// rtl/vote_session_ctrl_if.sv - ballot valid/ready handshake bundle between voter logic and vote_session_ctrl
interface vote_session_ctrl_if #(
    parameter int ID_W = 2
) ();
    logic            ballot_valid;
    logic [ID_W-1:0] ballot_id;
    logic            ballot_yes;
    logic            ballot_ready;

    modport master (output ballot_valid, ballot_id, ballot_yes, input ballot_ready);
    modport slave  (input ballot_valid, ballot_id, ballot_yes, output ballot_ready);
endinterface

// File: rtl/vote_ballot_box.sv
// rtl/vote_ballot_box.sv - voted mask, duplicate/range screening and yes/no counters for one session
module vote_ballot_box
    import vote_pkg::*;
#(
    parameter int N_VOTERS = 4,
    parameter int ID_W     = id_width(N_VOTERS),
    parameter int CNT_W    = cnt_width(N_VOTERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [ID_W-1:0]  id,
    input  logic             yes,
    output logic [CNT_W-1:0] yes_count,
    output logic [CNT_W-1:0] no_count,
    output logic             all_voted,
    output logic             reject
);

    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CNT_W-1:0]    yes_q, yes_d;
    logic [CNT_W-1:0]    no_q, no_d;
    logic                in_range;

    assign in_range = ($unsigned(32'(id)) < $unsigned(N_VOTERS));
    assign reject   = !in_range || voted_q[id];

    always_comb begin
        voted_d = voted_q;
        yes_d   = yes_q;
        no_d    = no_q;
        if (clear) begin
            voted_d = '0;
            yes_d   = '0;
            no_d    = '0;
        end else if (accept) begin
            voted_d[id] = 1'b1;
            if (yes) begin
                yes_d = yes_q + CNT_W'(1);
            end else begin
                no_d = no_q + CNT_W'(1);
            end
        end
    end

    // Auto-close looks at the mask including this cycle's ballot.
    assign all_voted = &voted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_q <= '0;
            yes_q   <= '0;
            no_q    <= '0;
        end else begin
            voted_q <= voted_d;
            yes_q   <= yes_d;
            no_q    <= no_d;
        end
    end

    assign yes_count = yes_q;
    assign no_count  = no_q;

endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - N-voter session FSM with ballot screening and pass evaluation
// Optional auto-close timer is built only when VOTE_TIMEOUT_EN is defined.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int N_VOTERS  = 4,
    parameter int ID_W      = id_width(N_VOTERS),
    parameter int CNT_W     = cnt_width(N_VOTERS),
    parameter int MODE      = MODE_MAJORITY,
    parameter int THRESHOLD = (N_VOTERS / 2) + 1,
    parameter int TIMEOUT   = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                close,
    vote_session_ctrl_if.slave  bal,
    output logic                ballot_err,
    output logic                busy,
    output logic                result_valid,
    output logic                pass,
    output logic [CNT_W-1:0]    yes_count,
    output logic [CNT_W-1:0]    no_count,
    output logic                timed_out
);

    vote_state_e      state_q, state_d;
    logic             err_q, err_d;
    logic             pass_q, pass_d;
    logic             ready;
    logic             hs;
    logic             accept;
    logic             reject;
    logic             all_voted;
    logic             open_entry;
    logic             timeout_hit;
    logic             pass_eval;
    logic [CNT_W-1:0] yes_cnt, no_cnt;

    assign ready  = (state_q == OPEN);
    assign hs     = bal.ballot_valid && ready;
    assign accept = hs && !reject;

    vote_ballot_box #(
        .N_VOTERS (N_VOTERS),
        .ID_W     (ID_W),
        .CNT_W    (CNT_W)
    ) u_box (
        .clk       (clk),
        .rst       (rst),
        .clear     (open_entry),
        .accept    (accept),
        .id        (bal.ballot_id),
        .yes       (bal.ballot_yes),
        .yes_count (yes_cnt),
        .no_count  (no_cnt),
        .all_voted (all_voted),
        .reject    (reject)
    );

    // A tie or an empty session fails under majority because yes > no is strict.
    assign pass_eval = (MODE == MODE_THRESHOLD) ? (yes_cnt >= CNT_W'(THRESHOLD))
                                                : (yes_cnt > no_cnt);

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        err_d      = 1'b0;
        open_entry = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = OPEN;
                    open_entry = 1'b1;
                    pass_d     = 1'b0;
                end
            end
            OPEN: begin
                err_d = hs && reject;
                if (close || all_voted || timeout_hit) begin
                    state_d = TALLY;
                end
            end
            TALLY: begin
                pass_d  = pass_eval;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

`ifdef VOTE_TIMEOUT_EN
    localparam int TM_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TM_W-1:0] timer_q, timer_d;
    logic            timed_out_q, timed_out_d;

    assign timeout_hit = (state_q == OPEN) && (timer_q == TM_W'(TIMEOUT - 1));

    always_comb begin
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
        if (open_entry) begin
            timer_d     = '0;
            timed_out_d = 1'b0;
        end else if (state_q == OPEN) begin
            timer_d = timer_q + TM_W'(1);
            // An explicit or auto close in the expiry cycle wins over the timeout flag.
            if (timeout_hit && !close && !all_voted) begin
                timed_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    assign bal.ballot_ready = ready;
    assign ballot_err       = err_q;
    assign busy             = (state_q == OPEN) || (state_q == TALLY);
    assign result_valid     = (state_q == DONE);
    assign pass             = pass_q;
    assign yes_count        = yes_cnt;
    assign no_count         = no_cnt;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - directed and random checks of two vote_session_ctrl builds against a rule-level model
`timescale 1ns/1ps
module tb_vote_session_ctrl;

    localparam int TMO = 16;
    localparam int S_IDLE = 0, S_OPEN = 1, S_TALLY = 2, S_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, close, bvalid, byes;
    logic [2:0] bid;

    logic       o_rdy [2];
    logic       o_err [2];
    logic       o_busy[2];
    logic       o_rv  [2];
    logic       o_pass[2];
    logic       o_to  [2];
    logic [2:0] o_yes [2];
    logic [2:0] o_no  [2];

    vote_session_ctrl_if #(.ID_W(2)) ia ();
    vote_session_ctrl_if #(.ID_W(3)) ib ();

    assign ia.ballot_valid = bvalid;
    assign ia.ballot_id    = bid[1:0];
    assign ia.ballot_yes   = byes;
    assign ib.ballot_valid = bvalid;
    assign ib.ballot_id    = bid;
    assign ib.ballot_yes   = byes;
    assign o_rdy[0]        = ia.ballot_ready;
    assign o_rdy[1]        = ib.ballot_ready;

    vote_session_ctrl #(.N_VOTERS(4), .TIMEOUT(TMO)) u_a (
        .clk(clk), .rst(rst), .start(start), .close(close), .bal(ia),
        .ballot_err(o_err[0]), .busy(o_busy[0]), .result_valid(o_rv[0]), .pass(o_pass[0]),
        .yes_count(o_yes[0]), .no_count(o_no[0]), .timed_out(o_to[0]));

    vote_session_ctrl #(.N_VOTERS(5), .MODE(1), .THRESHOLD(1), .TIMEOUT(TMO)) u_b (
        .clk(clk), .rst(rst), .start(start), .close(close), .bal(ib),
        .ballot_err(o_err[1]), .busy(o_busy[1]), .result_valid(o_rv[1]), .pass(o_pass[1]),
        .yes_count(o_yes[1]), .no_count(o_no[1]), .timed_out(o_to[1]));

    // Model: per-voter ballot record, head counts, and the pass rule as arithmetic.
    int       nv [2] = '{4, 5};
    int       idm[2] = '{3, 7};
    int       md [2] = '{0, 1};
    int       th [2] = '{3, 1};
    int       m_st [2];
    bit [7:0] m_voted[2];
    int       m_yes[2], m_no[2], m_tmr[2];
    bit       m_err[2], m_pass[2], m_to[2];

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string what, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", what, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = S_IDLE; m_voted[k] = '0; m_yes[k] = 0; m_no[k] = 0;
            m_tmr[k] = 0; m_err[k] = 0; m_pass[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step();
        int id;
        bit tmo_now;
        for (int k = 0; k < 2; k++) begin
            case (m_st[k])
                S_IDLE, S_DONE: begin
                    m_err[k] = 0;
                    if (start) begin
                        m_st[k] = S_OPEN; m_voted[k] = '0; m_yes[k] = 0; m_no[k] = 0;
                        m_pass[k] = 0; m_to[k] = 0; m_tmr[k] = 0;
                    end
                end
                S_OPEN: begin
                    m_err[k] = 0;
                    tmo_now  = 0;
                    if (bvalid) begin
                        id = int'(bid) & idm[k];
                        if (id < nv[k] && !m_voted[k][id]) begin
                            m_voted[k][id] = 1'b1;
                            if (byes) m_yes[k]++; else m_no[k]++;
                        end else begin
                            m_err[k] = 1;
                        end
                    end
`ifdef VOTE_TIMEOUT_EN
                    tmo_now = (m_tmr[k] == TMO - 1);
`endif
                    m_tmr[k]++;
                    if (close || $countones(m_voted[k]) == nv[k]) begin
                        m_st[k] = S_TALLY;
                    end else if (tmo_now) begin
                        m_st[k] = S_TALLY;
                        m_to[k] = 1;
                    end
                end
                default: begin
                    m_err[k]  = 0;
                    m_pass[k] = md[k] ? (m_yes[k] >= th[k]) : (m_yes[k] > m_no[k]);
                    m_st[k]   = S_DONE;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_ready"}, k, o_rdy[k], m_st[k] == S_OPEN);
            chk({tag, "_err"},   k, o_err[k], m_err[k]);
            chk({tag, "_busy"},  k, o_busy[k], m_st[k] == S_OPEN || m_st[k] == S_TALLY);
            chk({tag, "_rv"},    k, o_rv[k], m_st[k] == S_DONE);
            chk({tag, "_pass"},  k, o_pass[k], m_pass[k]);
            chk({tag, "_yes"},   k, o_yes[k], m_yes[k]);
            chk({tag, "_no"},    k, o_no[k], m_no[k]);
            chk({tag, "_to"},    k, o_to[k], m_to[k]);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_in();
        start = 0; close = 0; bvalid = 0; byes = 0; bid = '0;
    endtask

    task automatic ballot(input int id, input bit yes, input string tag);
        idle_in();
        bvalid = 1; bid = 3'(id); byes = yes;
        step(tag);
        bvalid = 0;
    endtask

    task automatic do_start(input string tag);
        idle_in(); start = 1; step(tag); start = 0;
    endtask

    task automatic do_close(input string tag);
        idle_in(); close = 1; step(tag); close = 0;
    endtask

    initial begin
        rst = 1; idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;
        step("idle");

        // Full N=4 session auto-closes on the last ballot
        do_start("t1_start");
        ballot(0, 1, "t1_b0"); ballot(1, 1, "t1_b1"); ballot(2, 0, "t1_b2"); ballot(3, 1, "t1_b3");
        chk("t1_tally_busy", 0, o_busy[0], 1);
        chk("t1_tally_rv",   0, o_rv[0], 0);
        idle_in(); step("t1_done");
        chk("t1_rv",   0, o_rv[0], 1);
        chk("t1_yes",  0, o_yes[0], 3);
        chk("t1_no",   0, o_no[0], 1);
        chk("t1_pass", 0, o_pass[0], 1);
        do_close("t1_close_b"); step("t1_b_tally"); step("t1_b_done");

        // Duplicate and out-of-range ballots
        do_start("t2_start");
        ballot(1, 1, "t2_b1");
        chk("t2_first_err", 0, o_err[0], 0);
        ballot(1, 0, "t2_dup");
        chk("t2_dup_err", 0, o_err[0], 1);
        chk("t2_dup_err", 1, o_err[1], 1);
        ballot(5, 1, "t2_range");
        chk("t2_range_err", 1, o_err[1], 1);
        idle_in(); step("t2_quiet");
        chk("t2_err_clr", 1, o_err[1], 0);
        chk("t2_yes", 1, o_yes[1], 1);
        chk("t2_no",  1, o_no[1], 0);
        do_close("t2_close"); step("t2_done");

        // Tie with early close: majority fails, threshold 1 passes
        do_start("t3_start");
        ballot(0, 1, "t3_b0"); ballot(1, 0, "t3_b1");
        do_close("t3_close"); step("t3_done");
        chk("t3_tie_pass", 0, o_pass[0], 0);
        chk("t3_thr_pass", 1, o_pass[1], 1);

        // Ballot and close together: ballot counted, then TALLY
        do_start("t4_start");
        idle_in(); close = 1; bvalid = 1; bid = 3'd2; byes = 1;
        step("t4_both");
        idle_in();
        chk("t4_yes",  0, o_yes[0], 1);
        chk("t4_busy", 0, o_busy[0], 1);
        chk("t4_rv",   0, o_rv[0], 0);
        step("t4_done");
        chk("t4_rv_done", 0, o_rv[0], 1);

        // Asynchronous reset mid-session discards the tally
        do_start("t5_start");
        ballot(0, 1, "t5_b0"); ballot(1, 0, "t5_b1");
        #3 rst = 1;
        #1;
        model_reset();
        check_all("t5_rst");
        chk("t5_rst_yes",  0, o_yes[0], 0);
        chk("t5_rst_busy", 1, o_busy[1], 0);
        @(posedge clk); #1;
        rst = 0;
        check_all("t5_rst_hold");
        do_start("t5_restart");
        ballot(0, 1, "t5_again");
        chk("t5_again_yes", 0, o_yes[0], 1);
        chk("t5_again_err", 0, o_err[0], 0);

        // Idle session: times out only when the timer is built
        idle_in();
        for (int i = 0; i < 20; i++) step("t6_wait");
`ifdef VOTE_TIMEOUT_EN
        chk("t6_rv", 0, o_rv[0], 1);
        chk("t6_to", 0, o_to[0], 1);
        do_start("t6_restart");
        chk("t6_to_clr", 0, o_to[0], 0);
`else
        chk("t6_still_open", 0, o_busy[0], 1);
        chk("t6_to_zero",    0, o_to[0], 0);
`endif
        do_close("t6_close"); step("t6_tally"); step("t6_settle");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 15) == 0);
            close  = ($urandom_range(0, 11) == 0);
            bvalid = $urandom_range(0, 1);
            bid    = 3'($urandom_range(0, 7));
            byes   = $urandom_range(0, 1);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
